// File: rtl/gx_block_window_2.sv
// gx_block_window_2 -- Sobel horizontal gradient (Gx) for window 2 (columns 1..3)
// of a 3-row x 4-column pixel strip. Column 0 belongs only to window 1 and is ignored.
// The result is registered with one clock of latency and loads only when enable_calc is high.
// Optional build macro: GX_ABS_EN. When it is defined, the output is |Gx| (unsigned)
// instead of the signed two's-complement Gx.
module gx_block_window_2 #(
   parameter int PIX_W = 8,
   parameter int OUT_W = 11
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [11:0][PIX_W-1:0] data_buffer,
   input  logic                   enable_calc,
   output logic [OUT_W-1:0]       gx_out_2
);

   // Per-row difference: right column (3) minus left column (1), zero-extended pixels.
   logic signed [OUT_W-1:0] row_diff [0:2];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         assign row_diff[gi] = $signed(OUT_W'(data_buffer[gi*4+3]))
                             - $signed(OUT_W'(data_buffer[gi*4+1]));
      end
   endgenerate

   logic signed [OUT_W-1:0] gx_sum;
   logic        [OUT_W-1:0] gx_val;
   logic        [OUT_W-1:0] gx_out_2_d;
   logic        [OUT_W-1:0] gx_out_2_q;

   // Weighted sum 1:2:1 down the rows, then the optional magnitude fold.
   always_comb begin
      gx_sum = row_diff[0] + (row_diff[1] <<< 1) + row_diff[2];
`ifdef GX_ABS_EN
      // The magnitude never exceeds 4*(2^PIX_W-1), so negating the most negative Gx is safe.
      gx_val = gx_sum[OUT_W-1] ? OUT_W'(-gx_sum) : OUT_W'(gx_sum);
`else
      gx_val = OUT_W'(gx_sum);
`endif
   end

   // Next-state logic: load a fresh result on enable; otherwise hold the current value.
   always_comb begin
      gx_out_2_d = gx_out_2_q;
      if (enable_calc) begin
         gx_out_2_d = gx_val;
      end
   end

   // Output register. Reset is synchronous, active high, and wins over enable_calc.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         gx_out_2_q <= '0;
      end else begin
         gx_out_2_q <= gx_out_2_d;
      end
   end

   assign gx_out_2 = gx_out_2_q;

endmodule

// File: tb/tb_gx_block_window_2.sv
// Self-checking bench for gx_block_window_2: directed steps followed by random traffic.
// A reference model recomputes Gx from the pixel rules using integer arithmetic.
module tb_gx_block_window_2;
   localparam int PIX_W = 8;
   localparam int OUT_W = 11;

   logic                   clk;
   logic                   n_rst;
   logic [11:0][PIX_W-1:0] data_buffer;
   logic                   enable_calc;
   logic [OUT_W-1:0]       gx_out_2;

   int n_total  = 0;
   int n_passed = 0;
   int n_failed = 0;
   int model_q  = 0;

   gx_block_window_2 #(.PIX_W(PIX_W), .OUT_W(OUT_W)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .data_buffer (data_buffer),
      .enable_calc (enable_calc),
      .gx_out_2    (gx_out_2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference Gx: row weights 1,2,1 applied to (column 3 - column 1); column 0 is unused.
   function automatic int gx_ref();
      int s = 0;
      for (int r = 0; r < 3; r++) begin
         int w = (r == 1) ? 2 : 1;
         s += w * (int'(data_buffer[r*4+3]) - int'(data_buffer[r*4+1]));
      end
`ifdef GX_ABS_EN
      if (s < 0) s = -s;
`endif
      return s;
   endfunction

   // Signed Gx value as seen at the output (magnitude when GX_ABS_EN is defined).
   function automatic int shown(input int v);
`ifdef GX_ABS_EN
      return (v < 0) ? -v : v;
`else
      return v;
`endif
   endfunction

   // Drive the control inputs, take one clock edge, update the model, then settle.
   task automatic step(input logic r, input logic e);
      n_rst       = r;
      enable_calc = e;
      @(posedge clk);
      if (r)      model_q = 0;
      else if (e) model_q = gx_ref();
      #1;
   endtask

   task automatic check(input string tag, input int expv);
      logic [OUT_W-1:0] e;
      e = OUT_W'(expv);
      n_total++;
      assert (gx_out_2 === e) begin
         n_passed++;
         $display("check %-10s observed=%h expected=%h", tag, gx_out_2, e);
      end else begin
         n_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, gx_out_2, e);
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 12; i++) data_buffer[i] = PIX_W'(v);
   endtask

   initial begin
      n_rst       = 1'b1;
      enable_calc = 1'b0;
      fill(0);
      #2;

      // 1: reset
      step(1'b1, 1'b0);
      check("reset", 0);

      // 2: bytes 0-5 = 100, bytes 6-11 = 200 -> +200
      for (int i = 0; i < 12; i++) data_buffer[i] = (i < 6) ? 8'd100 : 8'd200;
      step(1'b0, 1'b1);
      check("load200", 200);
      check("model200", model_q);

      // 3: hold while disabled, even with the data cleared
      fill(0);
      step(1'b0, 1'b0);
      check("hold", 200);
      step(1'b0, 1'b0);
      check("hold2", model_q);

      // 4: extremes of the range
      for (int r = 0; r < 3; r++) begin
         data_buffer[r*4+0] = PIX_W'($urandom_range(0, 255));
         data_buffer[r*4+1] = 8'd0;
         data_buffer[r*4+2] = PIX_W'($urandom_range(0, 255));
         data_buffer[r*4+3] = 8'd255;
      end
      step(1'b0, 1'b1);
      check("max", 1020);
      for (int r = 0; r < 3; r++) begin
         data_buffer[r*4+1] = 8'd255;
         data_buffer[r*4+3] = 8'd0;
      end
      step(1'b0, 1'b1);
      check("min", shown(-1020));

      // 5: uniform field, then disturbing only column 0, gives zero
      fill(77);
      step(1'b0, 1'b1);
      check("uniform", 0);
      data_buffer[0] = 8'd255;
      data_buffer[4] = 8'd255;
      data_buffer[8] = 8'd255;
      step(1'b0, 1'b1);
      check("col0", 0);

      // 6: reset pulse in a continuous stream
      for (int i = 0; i < 12; i++) data_buffer[i] = (i < 6) ? 8'd100 : 8'd200;
      step(1'b0, 1'b1);
      check("pre_rst", 200);
      step(1'b1, 1'b1);
      check("mid_rst", 0);
      step(1'b0, 1'b1);
      check("post_rst", 200);

      // Random traffic with occasional resets and gaps in enable_calc
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 5))
               0:       data_buffer[i] = 8'd0;
               1:       data_buffer[i] = 8'd255;
               default: data_buffer[i] = PIX_W'($urandom_range(0, 255));
            endcase
         end
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
         check("rand", model_q);
      end

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end
endmodule
